// File: rtl/b64to8_frame_unpacker.sv
// ---------------------------------------------------------------------------
// b64to8_frame_unpacker
//
// Reader side of the ADC sextet packer. Pops 64-bit packed words from a
// first-word-fall-through acquisition FIFO, checks frame/sextet sequencing
// and re-serialises the six ADC bytes of each word into a valid/ready byte
// stream tagged with the sample index, frame markers and header flags.
//
// Word layout:
//   [63]    HdrADC     [62] HdrShift     [61] HdrSwitch
//   [60:48] sextet number within the frame
//   [47:0]  six ADC bytes, byte k = [8k+7:8k], byte 0 is emitted first
//
// Ports:
//   InputClock   in   block clock
//   rst          in   synchronous, active-high reset
//   FifoData     in   FIFO head word (valid while FifoEmpty=0)
//   FifoEmpty    in   FIFO empty flag
//   FifoRdEn     out  pop strobe (combinational, gated by FifoEmpty and rst)
//   FrameLength  in   index of the last sextet in a frame
//   ByteOut      out  unpacked ADC sample
//   ByteValid    out  ByteOut valid
//   ByteReady    in   downstream accept
//   SampleIndex  out  sextet*6 + point within the frame
//   FrameStart   out  high with the byte at SampleIndex 0
//   FrameEnd     out  high with byte 5 of the last sextet of the frame
//   HdrADC/HdrShift/HdrSwitch  out  header bits of the latched word
//   SeqError     out  one-cycle pulse on a sequencing fault
//   FrameCount   out  completed frames, wraps
//
// Optional build macro UNPACK_STATS_EN adds:
//   ErrCount     out  saturating count of SeqError pulses
//   DropCount    out  saturating count of discarded words
// ---------------------------------------------------------------------------
module b64to8_frame_unpacker #(
  parameter int IDX_W       = 16,
  parameter int FRAME_CNT_W = 24
) (
  input  logic                   InputClock,
  input  logic                   rst,
  input  logic [63:0]            FifoData,
  input  logic                   FifoEmpty,
  output logic                   FifoRdEn,
  input  logic [12:0]            FrameLength,
  output logic [7:0]             ByteOut,
  output logic                   ByteValid,
  input  logic                   ByteReady,
  output logic [IDX_W-1:0]       SampleIndex,
  output logic                   FrameStart,
  output logic                   FrameEnd,
  output logic                   HdrADC,
  output logic                   HdrShift,
  output logic                   HdrSwitch,
  output logic                   SeqError,
  output logic [FRAME_CNT_W-1:0] FrameCount
`ifdef UNPACK_STATS_EN
  ,
  output logic [15:0]            ErrCount,
  output logic [15:0]            DropCount
`endif
);

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  localparam logic [IDX_W-1:0]       IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [FRAME_CNT_W-1:0] CNT_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

  // Byte k of the six-byte payload.
  function automatic logic [7:0] pickByte(input logic [47:0] w, input logic [2:0] k);
    logic [7:0] b;
    case (k)
      3'd0:    b = w[7:0];
      3'd1:    b = w[15:8];
      3'd2:    b = w[23:16];
      3'd3:    b = w[31:24];
      3'd4:    b = w[39:32];
      3'd5:    b = w[47:40];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Registered state
  logic [1:0]  state;
  logic [47:0] wordBytes;
  logic [12:0] curSextet;
  logic [2:0]  point;
  logic [12:0] expected;

  // Combinational helpers
  logic        accept;
  logic        wordDone;
  logic        frameDone;
  logic [12:0] expAfter;
  logic        popWindow;
  logic        popEn;
  logic [12:0] headSextet;
  logic [12:0] expUse;
  logic        rangeBad;
  logic        chkLatch;
  logic        chkErr;

  // Next-state values
  logic [1:0]             nState;
  logic [47:0]            nWord;
  logic [12:0]            nSextet;
  logic [2:0]             nPoint;
  logic [12:0]            nExpected;
  logic [IDX_W-1:0]       nIdx;
  logic                   nValid;
  logic [7:0]             nByte;
  logic [FRAME_CNT_W-1:0] nFrameCount;
  logic                   nSeqErr;
  logic [2:0]             nHdr;
  logic                   nDrop;
  logic                   nStart;
  logic                   nEnd;

  // Handshake and end-of-word / end-of-frame conditions
  always_comb begin
    accept    = ByteValid & ByteReady;
    wordDone  = accept && (point == 3'd5);
    frameDone = wordDone && (curSextet == FrameLength);
    if (frameDone) begin
      expAfter = 13'd0;
    end else begin
      expAfter = curSextet + 13'd1;
    end
  end

  // Pop strobe: must react to FifoEmpty in the same cycle, so it is not registered
  always_comb begin
    case (state)
      HUNT:    popWindow = 1'b1;
      IDLE:    popWindow = 1'b1;
      EMIT:    popWindow = wordDone;
      default: popWindow = 1'b0;
    endcase
    if (rst) begin
      popEn = 1'b0;
    end else begin
      popEn = popWindow & ~FifoEmpty;
    end
  end

  assign FifoRdEn = popEn;

  // Sequence check of the FIFO head word against the expected sextet
  always_comb begin
    headSextet = FifoData[60:48];
    // At end of word the expectation is the one being computed this cycle.
    if (state == EMIT) begin
      expUse = expAfter;
    end else begin
      expUse = expected;
    end
    rangeBad = (headSextet > FrameLength) || (expUse > FrameLength);
    chkLatch = 1'b0;
    chkErr   = 1'b0;
    if (state == HUNT) begin
      // Hunting silently discards everything until a frame start appears.
      chkLatch = (headSextet == 13'd0);
      chkErr   = 1'b0;
    end else if (rangeBad) begin
      chkErr   = 1'b1;
      chkLatch = 1'b0;
    end else if (headSextet == expUse) begin
      chkLatch = 1'b1;
      chkErr   = 1'b0;
    end else if (headSextet == 13'd0) begin
      // Truncated frame: flag it but resynchronise on the new frame start.
      chkErr   = 1'b1;
      chkLatch = 1'b1;
    end else begin
      chkErr   = 1'b1;
      chkLatch = 1'b0;
    end
  end

  // Next-state computation for the unpacker
  always_comb begin
    nState      = state;
    nWord       = wordBytes;
    nSextet     = curSextet;
    nPoint      = point;
    nExpected   = expected;
    nIdx        = SampleIndex;
    nValid      = ByteValid;
    nByte       = ByteOut;
    nFrameCount = FrameCount;
    nSeqErr     = 1'b0;
    nHdr        = {HdrADC, HdrShift, HdrSwitch};
    nDrop       = 1'b0;

    if ((state == EMIT) && accept) begin
      if (wordDone) begin
        nExpected = expAfter;
        nValid    = 1'b0;
        nState    = IDLE;
        if (frameDone) begin
          nIdx        = '0;
          nFrameCount = FrameCount + CNT_ONE;
        end else begin
          nIdx = SampleIndex + IDX_ONE;
        end
      end else begin
        nPoint = point + 3'd1;
        nIdx   = SampleIndex + IDX_ONE;
        nByte  = pickByte(wordBytes, point + 3'd1);
      end
    end else begin
      nPoint = point;
    end

    // A pop in EMIT overrides the IDLE fallback chosen above, giving a
    // bubble-free hand-over between words.
    if (popEn) begin
      nSeqErr = chkErr;
      if (chkLatch) begin
        nState  = EMIT;
        nWord   = FifoData[47:0];
        nSextet = headSextet;
        nPoint  = 3'd0;
        nIdx    = IDX_W'(headSextet) * IDX_W'(3'd6);
        nValid  = 1'b1;
        nByte   = FifoData[7:0];
        nHdr    = FifoData[63:61];
      end else begin
        nState    = HUNT;
        nValid    = 1'b0;
        nExpected = 13'd0;
        nDrop     = 1'b1;
      end
    end else begin
      nDrop = 1'b0;
    end

    nStart = nValid && (nIdx == '0);
    nEnd   = nValid && (nPoint == 3'd5) && (nSextet == FrameLength);
  end

  // State and registered outputs
  always_ff @(posedge InputClock) begin
    if (rst) begin
      state       <= HUNT;
      wordBytes   <= 48'd0;
      curSextet   <= 13'd0;
      point       <= 3'd0;
      expected    <= 13'd0;
      SampleIndex <= '0;
      ByteValid   <= 1'b0;
      ByteOut     <= 8'h00;
      FrameStart  <= 1'b0;
      FrameEnd    <= 1'b0;
      HdrADC      <= 1'b0;
      HdrShift    <= 1'b0;
      HdrSwitch   <= 1'b0;
      SeqError    <= 1'b0;
      FrameCount  <= '0;
    end else begin
      state       <= nState;
      wordBytes   <= nWord;
      curSextet   <= nSextet;
      point       <= nPoint;
      expected    <= nExpected;
      SampleIndex <= nIdx;
      ByteValid   <= nValid;
      ByteOut     <= nByte;
      FrameStart  <= nStart;
      FrameEnd    <= nEnd;
      HdrADC      <= nHdr[2];
      HdrShift    <= nHdr[1];
      HdrSwitch   <= nHdr[0];
      SeqError    <= nSeqErr;
      FrameCount  <= nFrameCount;
    end
  end

`ifdef UNPACK_STATS_EN
  // Saturating error and drop statistics
  always_ff @(posedge InputClock) begin
    if (rst) begin
      ErrCount  <= 16'd0;
      DropCount <= 16'd0;
    end else begin
      if (nSeqErr && (ErrCount != 16'hFFFF)) begin
        ErrCount <= ErrCount + 16'd1;
      end else begin
        ErrCount <= ErrCount;
      end
      if (nDrop && (DropCount != 16'hFFFF)) begin
        DropCount <= DropCount + 16'd1;
      end else begin
        DropCount <= DropCount;
      end
    end
  end
`endif

endmodule
